viewport_ctl: RTL and testbench

Viewport scroll controller for the BOTSIM video path. It turns the rojobot location updates into a map-window offset and moves that offset toward its target only at frame boundaries, so the picture never tears. The move is limited to a fixed step per frame, which makes the view glide instead of jump. It drives registered map row/column addresses to the map video port.

---
 rtl/bot_view_pkg.sv | 34 +++
 rtl/viewport_ctl_if.sv | 34 +++
 rtl/viewport_ctl_axis.sv | 81 ++++++++
 rtl/viewport_ctl.sv | 108 ++++++++++
 tb/tb_viewport_ctl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bot_view_pkg.sv
// bot_view_pkg
// Shared definitions for the viewport scroll controller:
//   - default window geometry (half window, largest offset, per-frame step)
//   - the controller state encoding
//   - clamp_target(): maps a bot location to a legal window offset
package bot_view_pkg;

  localparam int HALF_WIN_DEF = 32;
  localparam int MAX_OFF_DEF  = 192;
  localparam int STEP_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    SNAP  = 2'd2
  } view_state_t;

  // Centre the bot HALF_WIN cells into the window, but never scroll past
  // either edge of the map.
  function automatic logic [7:0] clamp_target(input logic [7:0] loc,
                                              input int half_win,
                                              input int max_off);
    int loc_i;
    loc_i = int'(loc);
    if (loc_i <= half_win) begin
      return 8'd0;
    end else if (loc_i >= max_off + half_win) begin
      return 8'(max_off);
    end else begin
      return 8'(loc_i - half_win);
    end
  endfunction

endpackage

// File: rtl/viewport_ctl_if.sv
// viewport_ctl_if
// Bundles the bot-location, video-timing and map-address signals of the
// viewport controller.
//   master : bot/video source side (drives locations, ticks, video address)
//   slave  : the controller (drives map address, offsets, busy)
interface viewport_ctl_if;

  logic        upd_sysregs;
  logic [7:0]  LocX;
  logic [7:0]  LocY;
  logic        follow_en;
  logic        recenter;
  logic        vid_frame_tick;
  logic [10:0] vid_row;
  logic [10:0] vid_col;
  logic [10:0] map_row;
  logic [10:0] map_col;
  logic [7:0]  off_x;
  logic [7:0]  off_y;
  logic        busy;

  modport master (
    output upd_sysregs, LocX, LocY, follow_en, recenter,
           vid_frame_tick, vid_row, vid_col,
    input  map_row, map_col, off_x, off_y, busy
  );

  modport slave (
    input  upd_sysregs, LocX, LocY, follow_en, recenter,
           vid_frame_tick, vid_row, vid_col,
    output map_row, map_col, off_x, off_y, busy
  );

endinterface

// File: rtl/viewport_ctl_axis.sv
// view_axis
// One scroll axis: target register, offset register, per-frame step/snap
// logic and the registered video-to-map address adder.
// Ports:
//   clk, reset     clock, async active-low reset
//   cap_en         capture a new target from loc this cycle
//   loc            bot location on this axis
//   tick           frame tick; offset may move only on this edge
//   snap           with tick: jump straight to target instead of stepping
//   vid_addr       video row/column address
//   off            current offset
//   at_target      offset equals target
//   map_addr       registered vid_addr + off (mod 2^11)
module view_axis
  import bot_view_pkg::*;
#(
  parameter int HALF_WIN = HALF_WIN_DEF,
  parameter int MAX_OFF  = MAX_OFF_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_en,
  input  logic [7:0]  loc,
  input  logic        tick,
  input  logic        snap,
  input  logic [10:0] vid_addr,
  output logic [7:0]  off,
  output logic        at_target,
  output logic [10:0] map_addr
);

  localparam logic [7:0] STEP_W = 8'(STEP);

  logic [7:0]  target_q, target_d;
  logic [7:0]  off_q, off_d;
  logic [10:0] map_addr_q, map_addr_d;

  always_comb begin
    target_d = target_q;
    if (cap_en) begin
      target_d = clamp_target(loc, HALF_WIN, MAX_OFF);
    end
  end

  // The step always uses the target registered before this edge, so a
  // capture coinciding with a tick only takes effect on the next tick.
  always_comb begin
    off_d = off_q;
    if (tick) begin
      if (snap) begin
        off_d = target_q;
      end else if (target_q > off_q) begin
        off_d = ((target_q - off_q) > STEP_W) ? (off_q + STEP_W) : target_q;
      end else if (target_q < off_q) begin
        off_d = ((off_q - target_q) > STEP_W) ? (off_q - STEP_W) : target_q;
      end
    end
  end

  always_comb begin
    map_addr_d = vid_addr + {3'b000, off_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q   <= 8'd0;
      off_q      <= 8'd0;
      map_addr_q <= 11'd0;
    end else begin
      target_q   <= target_d;
      off_q      <= off_d;
      map_addr_q <= map_addr_d;
    end
  end

  assign off       = off_q;
  assign at_target = (off_q == target_q);
  assign map_addr  = map_addr_q;

endmodule

// File: rtl/viewport_ctl.sv
// viewport_ctl
// Viewport scroll controller: turns bot location updates into a map-window
// offset that glides toward its target by at most STEP per frame tick, or
// snaps to it on the tick after a recenter request.
// Ports:
//   clk    system clock
//   reset  async active-low reset
//   bus    viewport_ctl_if.slave: LocX/LocY/upd_sysregs/follow_en/recenter,
//          vid_frame_tick, vid_row/vid_col in; map_row/map_col, off_x/off_y,
//          busy out
//
// state | meaning
// IDLE  | both offsets at target, no snap pending
// TRACK | at least one offset still gliding toward its target
// SNAP  | recenter pending; next frame tick jumps to target
module viewport_ctl
  import bot_view_pkg::*;
#(
  parameter int HALF_WIN = HALF_WIN_DEF,
  parameter int MAX_OFF  = MAX_OFF_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic           clk,
  input  logic           reset,
  viewport_ctl_if.slave  bus
);

  logic        snap_pend_q, snap_pend_d;
  view_state_t state_q, state_d;
  logic        cap_en;
  logic        at_x, at_y;
  logic        busy;

  assign cap_en = bus.upd_sysregs & bus.follow_en;

  // A recenter that arrives with a tick must survive that tick so the snap
  // lands on the following one.
  always_comb begin
    snap_pend_d = snap_pend_q;
    if (bus.recenter) begin
      snap_pend_d = 1'b1;
    end else if (bus.vid_frame_tick) begin
      snap_pend_d = 1'b0;
    end
  end

  // The axes act on snap_pend directly rather than on the lagging state so
  // a tick arriving right after a recenter still snaps.
  view_axis #(
    .HALF_WIN (HALF_WIN),
    .MAX_OFF  (MAX_OFF),
    .STEP     (STEP)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .loc       (bus.LocX),
    .tick      (bus.vid_frame_tick),
    .snap      (snap_pend_q),
    .vid_addr  (bus.vid_col),
    .off       (bus.off_x),
    .at_target (at_x),
    .map_addr  (bus.map_col)
  );

  view_axis #(
    .HALF_WIN (HALF_WIN),
    .MAX_OFF  (MAX_OFF),
    .STEP     (STEP)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .loc       (bus.LocY),
    .tick      (bus.vid_frame_tick),
    .snap      (snap_pend_q),
    .vid_addr  (bus.vid_row),
    .off       (bus.off_y),
    .at_target (at_y),
    .map_addr  (bus.map_row)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      snap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_pend_q <= snap_pend_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (snap_pend_q) begin
      state_d = SNAP;
    end else if (!(at_x && at_y)) begin
      state_d = TRACK;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_viewport_ctl.sv
module tb_viewport_ctl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  viewport_ctl_if vif ();

  viewport_ctl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (vif)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain integer view of the window.
  int m_tx, m_ty, m_ox, m_oy, m_mrow, m_mcol;
  bit m_snap, m_busy;

  function automatic int tgt_of(input int loc);
    if (loc <= 32) return 0;
    if (loc >= 224) return 192;
    return loc - 32;
  endfunction

  function automatic int glide(input int o, input int t);
    int d;
    d = t - o;
    if (d > 4) d = 4;
    if (d < -4) d = -4;
    return o + d;
  endfunction

  task automatic model_reset();
    m_tx = 0; m_ty = 0; m_ox = 0; m_oy = 0;
    m_mrow = 0; m_mcol = 0; m_snap = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    bit busy_n;
    busy_n = m_snap || (m_ox != m_tx) || (m_oy != m_ty);
    m_mcol = (int'(vif.vid_col) + m_ox) % 2048;
    m_mrow = (int'(vif.vid_row) + m_oy) % 2048;
    if (vif.vid_frame_tick) begin
      if (m_snap) begin
        m_ox = m_tx; m_oy = m_ty;
      end else begin
        m_ox = glide(m_ox, m_tx); m_oy = glide(m_oy, m_ty);
      end
    end
    if (vif.upd_sysregs && vif.follow_en) begin
      m_tx = tgt_of(int'(vif.LocX));
      m_ty = tgt_of(int'(vif.LocY));
    end
    if (vif.recenter) m_snap = 1;
    else if (vif.vid_frame_tick) m_snap = 0;
    m_busy = busy_n;
  endtask

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("off_x",   {3'b000, vif.off_x}, 11'(m_ox));
    chk("off_y",   {3'b000, vif.off_y}, 11'(m_oy));
    chk("busy",    {10'd0, vif.busy},   11'(m_busy));
    chk("map_row", vif.map_row,         11'(m_mrow));
    chk("map_col", vif.map_col,         11'(m_mcol));
  endtask

  // One clock with the current inputs, then pulses drop and outputs are checked.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    vif.upd_sysregs    = 1'b0;
    vif.recenter       = 1'b0;
    vif.vid_frame_tick = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  int locs [4] = '{32, 33, 224, 250};
  int exps [4] = '{0, 1, 192, 192};

  initial begin
    vif.upd_sysregs    = 1'b0;
    vif.LocX           = 8'd0;
    vif.LocY           = 8'd0;
    vif.follow_en      = 1'b1;
    vif.recenter       = 1'b0;
    vif.vid_frame_tick = 1'b0;
    vif.vid_row        = 11'd0;
    vif.vid_col        = 11'd0;
    model_reset();
    do_reset();

    // Glide: targets 68/0, 17 ticks of 4.
    vif.LocX = 8'd100; vif.LocY = 8'd20; vif.upd_sysregs = 1'b1;
    cyc();
    for (int k = 1; k <= 17; k++) begin
      vif.vid_frame_tick = 1'b1;
      cyc();
      chk("glide_x", {3'b000, vif.off_x}, 11'(4 * k));
      chk("glide_y", {3'b000, vif.off_y}, 11'd0);
      cyc();
      chk("glide_busy", {10'd0, vif.busy}, (k < 17) ? 11'd1 : 11'd0);
      cyc();
    end

    // Clamp boundaries, observed by snapping to the target.
    for (int i = 0; i < 4; i++) begin
      vif.LocX = 8'(locs[i]); vif.upd_sysregs = 1'b1;
      cyc();
      vif.recenter = 1'b1;
      cyc();
      vif.vid_frame_tick = 1'b1;
      cyc();
      chk("clamp_x", {3'b000, vif.off_x}, 11'(exps[i]));
      cyc();
    end

    // Recenter from 0 to 68 in one tick.
    do_reset();
    vif.LocX = 8'd100; vif.LocY = 8'd20; vif.upd_sysregs = 1'b1;
    cyc();
    vif.recenter = 1'b1;
    cyc();
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    chk("snap_x", {3'b000, vif.off_x}, 11'd68);
    cyc();
    chk("snap_busy", {10'd0, vif.busy}, 11'd0);

    // Recenter together with a tick: tick steps, snap fires on the next one.
    vif.LocX = 8'd200; vif.upd_sysregs = 1'b1;
    cyc();
    vif.recenter = 1'b1; vif.vid_frame_tick = 1'b1;
    cyc();
    chk("rc_tick_step", {3'b000, vif.off_x}, 11'd72);
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    chk("rc_tick_snap", {3'b000, vif.off_x}, 11'd168);

    // Same-cycle update and tick.
    vif.LocX = 8'd72; vif.upd_sysregs = 1'b1;
    cyc();
    vif.recenter = 1'b1;
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    chk("same_pre", {3'b000, vif.off_x}, 11'd40);
    cyc();
    cyc();
    vif.LocX = 8'd120; vif.upd_sysregs = 1'b1; vif.vid_frame_tick = 1'b1;
    cyc();
    chk("same_hold", {3'b000, vif.off_x}, 11'd40);
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    chk("same_next", {3'b000, vif.off_x}, 11'd44);
    vif.recenter = 1'b1;
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    chk("same_tgt", {3'b000, vif.off_x}, 11'd88);

    // Address path with wrap.
    vif.LocX = 8'd100; vif.LocY = 8'd250; vif.upd_sysregs = 1'b1;
    cyc();
    vif.recenter = 1'b1;
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    vif.vid_col = 11'd10; vif.vid_row = 11'd2040;
    cyc();
    chk("addr_col", vif.map_col, 11'd78);
    chk("addr_row", vif.map_row, 11'd184);

    // follow_en=0 freezes the target.
    vif.vid_col = 11'd0; vif.vid_row = 11'd0;
    vif.follow_en = 1'b0; vif.LocX = 8'd40; vif.upd_sysregs = 1'b1;
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    chk("frozen_x", {3'b000, vif.off_x}, 11'd68);
    vif.follow_en = 1'b1;

    // Asynchronous reset mid-scroll.
    vif.LocX = 8'd250; vif.LocY = 8'd250; vif.upd_sysregs = 1'b1;
    cyc();
    vif.vid_frame_tick = 1'b1;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_off_x", {3'b000, vif.off_x}, 11'd0);
    chk("arst_busy", {10'd0, vif.busy}, 11'd0);
    check_model();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vif.vid_frame_tick = 1'b1;
      cyc();
      cyc();
    end
    chk("arst_still", {3'b000, vif.off_x}, 11'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      vif.upd_sysregs    = ($urandom_range(0, 7) == 0);
      vif.LocX           = 8'($urandom_range(0, 255));
      vif.LocY           = 8'($urandom_range(0, 255));
      vif.follow_en      = ($urandom_range(0, 9) != 0);
      vif.recenter       = ($urandom_range(0, 39) == 0);
      vif.vid_frame_tick = ($urandom_range(0, 4) == 0);
      vif.vid_row        = 11'($urandom_range(0, 2047));
      vif.vid_col        = 11'($urandom_range(0, 2047));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
